// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared decode constants for the instruction-decode stage
package id_stage_pkg;

   // Execute-unit command codes carried to EX
   localparam logic [3:0] EXE_NOP = 4'b0000;
   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;

   // Data-processing opcodes (instruction[24:21])
   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_EOR = 4'b0001,
      OP_SUB = 4'b0010,
      OP_ADD = 4'b0100,
      OP_ADC = 4'b0101,
      OP_SBC = 4'b0110,
      OP_TST = 4'b1000,
      OP_CMP = 4'b1010,
      OP_ORR = 4'b1100,
      OP_MOV = 4'b1101,
      OP_MVN = 4'b1111
   } opcodeE;

   // Condition field (instruction[31:28])
   typedef enum logic [3:0] {
      COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
      COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
      COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
      COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
   } condE;

   // Instruction class (instruction[27:26])
   typedef enum logic [1:0] {
      MODE_ALU    = 2'b00,
      MODE_MEM    = 2'b01,
      MODE_BRANCH = 2'b10,
      MODE_NONE   = 2'b11
   } modeE;

   // Field positions within the instruction word
   localparam int COND_LSB   = 28;
   localparam int MODE_LSB   = 26;
   localparam int IMM_BIT    = 25;
   localparam int OPCODE_LSB = 21;
   localparam int S_BIT      = 20;
   localparam int RN_LSB     = 16;
   localparam int RD_LSB     = 12;
   localparam int SHIFT_LSB  = 0;
   localparam int RM_LSB     = 0;
   localparam int IMM24_LSB  = 0;

   // Bit positions within the {N,Z,C,V} status word
   localparam int STATUS_N = 3;
   localparam int STATUS_Z = 2;
   localparam int STATUS_C = 1;
   localparam int STATUS_V = 0;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - general register file, two async reads with write-through
module register_file #(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic [WIDTH-1:0] pc,
   input  logic             wbWbEn,
   input  logic [3:0]       wbDest,
   input  logic [WIDTH-1:0] wbValue,
   output logic [WIDTH-1:0] val1,
   output logic [WIDTH-1:0] val2
);
   import id_stage_pkg::*;

   logic [WIDTH-1:0] regs [NUM_REGS];
   logic             wrHit;

   // Index 15 is the PC alias and never holds state
   assign wrHit = wbWbEn && (int'(wbDest) < NUM_REGS);

   // Read port: PC alias, then same-cycle write-back bypass, then stored value
   function automatic logic [WIDTH-1:0] readPort(input logic [3:0] idx);
      if (int'(idx) >= NUM_REGS)
         return pc;
      else if (wrHit && (wbDest == idx))
         return wbValue;
      else
         return regs[idx];
   endfunction

   // Combinational read ports
   always_comb begin
      val1 = readPort(src1);
      val2 = readPort(src2);
   end

   // Reset seeds r[i] = i; otherwise commit the write-back (reset wins over it)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= WIDTH'(i);
      end else if (wrHit) begin
         regs[wbDest] <= wbValue;
      end
   end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode, condition check and ID/EX pipeline register
module id_stage #(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             hazard,
   input  logic [31:0]      instruction,
   input  logic [WIDTH-1:0] PC,
   input  logic [3:0]       status,
   input  logic             wbWbEn,
   input  logic [3:0]       wbDest,
   input  logic [WIDTH-1:0] wbValue,
   output logic [3:0]       src1,
   output logic [3:0]       src2,
   output logic             twoSrc,
   output logic [WIDTH-1:0] exPC,
   output logic [WIDTH-1:0] exValRn,
   output logic [WIDTH-1:0] exValRm,
   output logic             exImm,
   output logic [11:0]      exShiftOperand,
   output logic [23:0]      exSignedImm24,
   output logic [3:0]       exDest,
   output logic [3:0]       exExeCmd,
   output logic             exMemR,
   output logic             exMemW,
   output logic             exWbEn,
   output logic             exB,
   output logic             exS
);
   import id_stage_pkg::*;

   condE        cond;
   modeE        mode;
   opcodeE      opcode;
   logic        iBit;
   logic        sBit;
   logic [3:0]  rn;
   logic [3:0]  rd;
   logic [3:0]  rm;

   assign cond   = condE'(instruction[COND_LSB +: 4]);
   assign mode   = modeE'(instruction[MODE_LSB +: 2]);
   assign opcode = opcodeE'(instruction[OPCODE_LSB +: 4]);
   assign iBit   = instruction[IMM_BIT];
   assign sBit   = instruction[S_BIT];
   assign rn     = instruction[RN_LSB +: 4];
   assign rd     = instruction[RD_LSB +: 4];
   assign rm     = instruction[RM_LSB +: 4];

   logic [3:0] exeCmdDec;
   logic       wbEnDec;
   logic       memRDec;
   logic       memWDec;
   logic       bDec;
   logic       sDec;

   // Control decode by instruction class and opcode, before condition/hazard gating
   always_comb begin
      exeCmdDec = EXE_NOP;
      wbEnDec   = 1'b0;
      memRDec   = 1'b0;
      memWDec   = 1'b0;
      bDec      = 1'b0;
      sDec      = 1'b0;
      case (mode)
         MODE_ALU: begin
            wbEnDec = 1'b1;
            sDec    = sBit;
            case (opcode)
               OP_MOV:  exeCmdDec = EXE_MOV;
               OP_MVN:  exeCmdDec = EXE_MVN;
               OP_ADD:  exeCmdDec = EXE_ADD;
               OP_ADC:  exeCmdDec = EXE_ADC;
               OP_SUB:  exeCmdDec = EXE_SUB;
               OP_SBC:  exeCmdDec = EXE_SBC;
               OP_AND:  exeCmdDec = EXE_AND;
               OP_ORR:  exeCmdDec = EXE_ORR;
               OP_EOR:  exeCmdDec = EXE_EOR;
               OP_CMP: begin
                  exeCmdDec = EXE_SUB;
                  wbEnDec   = 1'b0;
               end
               OP_TST: begin
                  exeCmdDec = EXE_AND;
                  wbEnDec   = 1'b0;
               end
               default: begin
                  wbEnDec = 1'b0;
                  sDec    = 1'b0;
               end
            endcase
         end
         MODE_MEM: begin
            // The S bit doubles as the load/store select for memory ops
            exeCmdDec = EXE_ADD;
            if (sBit) begin
               memRDec = 1'b1;
               wbEnDec = 1'b1;
            end else begin
               memWDec = 1'b1;
            end
         end
         MODE_BRANCH: bDec = 1'b1;
         default: ;
      endcase
   end

   logic condOk;
   logic flagN, flagZ, flagC, flagV;

   assign flagN = status[STATUS_N];
   assign flagZ = status[STATUS_Z];
   assign flagC = status[STATUS_C];
   assign flagV = status[STATUS_V];

   // ARM condition evaluation against the current flags
   always_comb begin
      condOk = 1'b0;
      case (cond)
         COND_EQ: condOk = flagZ;
         COND_NE: condOk = ~flagZ;
         COND_CS: condOk = flagC;
         COND_CC: condOk = ~flagC;
         COND_MI: condOk = flagN;
         COND_PL: condOk = ~flagN;
         COND_VS: condOk = flagV;
         COND_VC: condOk = ~flagV;
         COND_HI: condOk = flagC & ~flagZ;
         COND_LS: condOk = ~flagC | flagZ;
         COND_GE: condOk = (flagN == flagV);
         COND_LT: condOk = (flagN != flagV);
         COND_GT: condOk = ~flagZ & (flagN == flagV);
         COND_LE: condOk = flagZ | (flagN != flagV);
         COND_AL: condOk = 1'b1;
         default: condOk = 1'b0;
      endcase
   end

   // Source selection for the hazard unit; stores read Rd as their data source.
   // Uses the ungated decode so hazard detection never depends on its own result.
   assign src1   = rn;
   assign src2   = memWDec ? rd : rm;
   assign twoSrc = (~iBit & (mode == MODE_ALU)) | memWDec;

   logic [WIDTH-1:0] valRn;
   logic [WIDTH-1:0] valRm;

   register_file #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS)
   ) u_register_file (
      .clk     (clk),
      .rst     (rst),
      .src1    (src1),
      .src2    (src2),
      .pc      (PC),
      .wbWbEn  (wbWbEn),
      .wbDest  (wbDest),
      .wbValue (wbValue),
      .val1    (valRn),
      .val2    (valRm)
   );

   logic ctrlEn;

   // A failed condition or a hazard bubble kills side effects but keeps the data
   assign ctrlEn = condOk & ~hazard;

   // ID/EX register: reset and flush clear, freeze holds, otherwise load
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         exPC           <= '0;
         exValRn        <= '0;
         exValRm        <= '0;
         exImm          <= 1'b0;
         exShiftOperand <= '0;
         exSignedImm24  <= '0;
         exDest         <= '0;
         exExeCmd       <= '0;
         exMemR         <= 1'b0;
         exMemW         <= 1'b0;
         exWbEn         <= 1'b0;
         exB            <= 1'b0;
         exS            <= 1'b0;
      end else if (!freeze) begin
         exPC           <= PC;
         exValRn        <= valRn;
         exValRm        <= valRm;
         exImm          <= iBit;
         exShiftOperand <= instruction[SHIFT_LSB +: 12];
         exSignedImm24  <= instruction[IMM24_LSB +: 24];
         exDest         <= rd;
         exExeCmd       <= exeCmdDec;
         exMemR         <= memRDec & ctrlEn;
         exMemW         <= memWDec & ctrlEn;
         exWbEn         <= wbEnDec & ctrlEn;
         exB            <= bDec & ctrlEn;
         exS            <= sDec & ctrlEn;
      end
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter WIDTH, 32, datapath and PC width.
REQ-002 Parameter NUM_REGS, 15, general registers r0..r14 held in the register file.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 freeze  input  1  hold ID/EX register.
REQ-006 flush  input  1  branch taken in EXE; kill ID/EX contents.
REQ-007 hazard  input  1  from hazard unit; insert bubble.
REQ-008 instruction, PC  input  32 each  from IF/ID register.
REQ-009 status  input  4  {N,Z,C,V} from status register.
REQ-010 wbWbEn, wbDest, wbValue  input  1/4/32  write-back port.
REQ-011 src1, src2  output  4  Rn, and Rm or Rd; to hazard unit.
REQ-012 twoSrc  output  1  src2 is a real read.
REQ-013 exPC, exValRn, exValRm  output  32 each  ID/EX data.
REQ-014 exImm, exShiftOperand, exSignedImm24, exDest  output  1/12/24/4.
REQ-015 exExeCmd  output  4; exMemR, exMemW, exWbEn, exB, exS  output  1 each.

Function
REQ-016 Decode fields: cond[31:28], I[25], mode[27:26], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shiftOperand[11:0], Rm[3:0], imm24[23:0].
REQ-017 Mode 00 exeCmd map: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; wbEn=1 except CMP/TST; any other opcode gives no-op (all controls 0).
REQ-018 Mode 01: S=1 LDR (exeCmd 0010, memR=1, wbEn=1); S=0 STR (exeCmd 0010, memW=1). Mode 10: B=1, all other controls 0. Mode 11: no-op.
REQ-019 Condition check per ARM: EQ,NE,CS,CC,MI,PL,VS,VC,HI (C&~Z),LS (~C|Z),GE (N==V),LT,GT (~Z&N==V),LE,AL=1; 1111 false.
REQ-020 Controls (wbEn, memR, memW, B, S) forced 0 when condition false or hazard=1; data fields still loaded.
REQ-021 src1=Rn; src2=Rd when memW else Rm; twoSrc = (~I & mode==00) | memW.
REQ-022 Register file: two combinational reads, one synchronous write of wbValue to r[wbDest] when wbWbEn=1 and wbDest<15.
REQ-023 Write-through: a read of the register being written in the same cycle returns wbValue.
REQ-024 Read index 15 returns PC input; write to index 15 ignored.
REQ-025 ID/EX update priority per edge: rst > flush > freeze > load; flush clears all ID/EX outputs to 0; freeze holds all.
REQ-026 Latency: decoded instruction appears on ID/EX outputs one cycle after presentation.
REQ-027 Register file writes occur regardless of freeze/flush/hazard.

Reset
REQ-028 rst=1 at an edge: all ID/EX outputs 0; r[i] = i for i=0..14.
REQ-029 rst mid-operation discards any in-flight write-back in that cycle.

Structure
REQ-030 Shared package holds exeCmd codes, opcode/cond/mode enums and field-position constants.
REQ-031 Register file is a sub-module named register_file; decode and condition check stay in id_stage.

Verification
REQ-032 After reset, ADD r1,r2,r3 (0xE0821003) -> next cycle exeCmd=0010, wbEn=1, exValRn=2, exValRm=3, exDest=1.
REQ-033 MOVEQ r0,#5 with status Z=0 -> wbEn=0, exImm=1, exShiftOperand=0x005; with Z=1 -> wbEn=1.
REQ-034 wbWbEn=1, wbDest=4, wbValue=0xDEADBEEF same cycle as reading r4 -> exValRn=0xDEADBEEF; later reads keep it.
REQ-035 STR r5,[r6] (0xE5865000): src1=6, src2=5, twoSrc=1; with hazard=1 -> exMemW=0.
REQ-036 flush and freeze both high with valid LDR -> all ID/EX outputs 0; freeze alone -> outputs unchanged.
REQ-037 Branch 0xEA000010 -> exB=1, exSignedImm24=0x000010, exWbEn=0.
